mcs4_bus_monitor: RTL and testbench

Passive observer on the MCS-4 system bus, downstream of the i4004 CPU and i4001 ROM. It watches PHI2, SYNC and the 4-bit data bus and decodes the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3). It reports every instruction fetch as a 12-bit address plus an 8-bit opcode, one pulse per fetch, for benches and on-board trace logic. It never drives the bus.

---
 rtl/mcs4_bus_monitor.sv | 121 ++++++++++++
 tb/tb_mcs4_bus_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_monitor.sv
// mcs4_bus_monitor
//   Passive observer of the MCS-4 bus. It tracks the eight-subcycle instruction
//   cycle (A1 A2 A3 M1 M2 X1 X2 X3) from PHI2 and SYNC. Each instruction fetch
//   is reported as a 12-bit address and an 8-bit opcode, with a one-clock pulse.
//   The bus is only observed, never driven.
//
// Ports
//   clk_i          system clock (also drives mcs4_clk_gen)
//   rst_ni         synchronous active-low reset
//   PHI2_i         phase-2 clock, synchronous to clk_i
//   SYNC_i         CPU SYNC, high during X3
//   D_i[3:0]       data bus (observe only)
//   locked_o       subcycle counter aligned to SYNC
//   phase_o[2:0]   current subcycle, 0=A1 .. 7=X3
//   fetch_valid_o  one-clock pulse when a new fetch is presented
//   fetch_addr_o   fetch address {A3,A2,A1}
//   fetch_op_o     opcode {OPR,OPA}
//   sync_err_o     one-clock pulse on early or missing SYNC
//   fetch_cnt_o    wrapping count of reported fetches
module mcs4_bus_monitor #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 PHI2_i,
   input  logic                 SYNC_i,
   input  logic [3:0]           D_i,
   output logic                 locked_o,
   output logic [2:0]           phase_o,
   output logic                 fetch_valid_o,
   output logic [11:0]          fetch_addr_o,
   output logic [7:0]           fetch_op_o,
   output logic                 sync_err_o,
   output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

   typedef enum logic [2:0] {
      PH_A1 = 3'd0,
      PH_A2 = 3'd1,
      PH_A3 = 3'd2,
      PH_M1 = 3'd3,
      PH_M2 = 3'd4,
      PH_X1 = 3'd5,
      PH_X2 = 3'd6,
      PH_X3 = 3'd7
   } phase_t;

   phase_t      phase_q;
   phase_t      phase_d;
   logic [2:0]  phase_inc;
   logic        locked_d;
   logic        err_d;
   logic        phi2_q;
   logic        tick;
   logic [11:0] addr_q;
   logic [3:0]  op_hi_q;

   // Rising edge of PHI2: one clk per subcycle, the only clk the bus is sampled in.
   assign tick    = PHI2_i & ~phi2_q;
   assign phase_o = phase_q;

   // Next subcycle and lock state for a tick clk.
   always_comb begin
      phase_inc = phase_q + 3'd1;
      phase_d   = phase_t'(phase_inc);
      locked_d  = locked_o;
      err_d     = 1'b0;
      if (SYNC_i) begin
         phase_d  = PH_X3;
         locked_d = 1'b1;
         err_d    = locked_o && (phase_q != PH_X2);
      end else if (locked_o && (phase_q == PH_X2)) begin
         // SYNC was due here: drop lock and park on X3 until the next SYNC.
         phase_d  = PH_X3;
         locked_d = 1'b0;
         err_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         phi2_q        <= 1'b0;
         phase_q       <= PH_A1;
         locked_o      <= 1'b0;
         sync_err_o    <= 1'b0;
         fetch_valid_o <= 1'b0;
         fetch_addr_o  <= '0;
         fetch_op_o    <= '0;
         fetch_cnt_o   <= '0;
         addr_q        <= '0;
         op_hi_q       <= '0;
      end else begin
         phi2_q        <= PHI2_i;
         fetch_valid_o <= 1'b0;
         sync_err_o    <= 1'b0;
         if (tick) begin
            phase_q    <= phase_d;
            locked_o   <= locked_d;
            sync_err_o <= err_d;
            // Locking only happens via SYNC (phase X3), so reaching M2 while
            // locked implies A1..M1 of this cycle have all been captured.
            if (locked_d) begin
               case (phase_d)
                  PH_A1: addr_q[3:0]  <= D_i;
                  PH_A2: addr_q[7:4]  <= D_i;
                  PH_A3: addr_q[11:8] <= D_i;
                  PH_M1: op_hi_q      <= D_i;
                  PH_M2: begin
                     fetch_valid_o <= 1'b1;
                     fetch_addr_o  <= addr_q;
                     fetch_op_o    <= {op_hi_q, D_i};
                     fetch_cnt_o   <= fetch_cnt_o + 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_mcs4_bus_monitor.sv
module tb_mcs4_bus_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        phi2;
   logic        sync;
   logic [3:0]  d;

   logic        locked, locked2;
   logic [2:0]  phase, phase2;
   logic        fvalid, fvalid2;
   logic [11:0] faddr, faddr2;
   logic [7:0]  fop, fop2;
   logic        serr, serr2;
   logic [15:0] fcnt;
   logic [1:0]  fcnt2;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mcs4_bus_monitor #(.CNT_WIDTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .PHI2_i(phi2), .SYNC_i(sync), .D_i(d),
      .locked_o(locked), .phase_o(phase), .fetch_valid_o(fvalid),
      .fetch_addr_o(faddr), .fetch_op_o(fop), .sync_err_o(serr), .fetch_cnt_o(fcnt)
   );

   mcs4_bus_monitor #(.CNT_WIDTH(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .PHI2_i(phi2), .SYNC_i(sync), .D_i(d),
      .locked_o(locked2), .phase_o(phase2), .fetch_valid_o(fvalid2),
      .fetch_addr_o(faddr2), .fetch_op_o(fop2), .sync_err_o(serr2), .fetch_cnt_o(fcnt2)
   );

   // ---------------- reference model (tick level) ----------------
   int          m_phase;
   bit          m_locked;
   logic [3:0]  nibs[$];
   int unsigned m_cnt;
   bit          e_err, e_valid;
   logic [11:0] e_addr;
   logic [7:0]  e_op;

   function automatic void model_reset();
      m_phase = 0; m_locked = 0; nibs.delete(); m_cnt = 0;
      e_err = 0; e_valid = 0; e_addr = '0; e_op = '0;
   endfunction

   // Nibbles seen since the last SYNC are queued; the fifth one completes a fetch.
   function automatic void model_step(bit s, logic [3:0] dv);
      e_err = 0; e_valid = 0;
      if (s) begin
         e_err = m_locked && (m_phase != 6);
         m_phase = 7; m_locked = 1; nibs.delete();
      end else if (m_locked && m_phase == 6) begin
         e_err = 1; m_locked = 0; m_phase = 7; nibs.delete();
      end else begin
         m_phase = (m_phase + 1) % 8;
         if (m_locked && m_phase <= 4) begin
            nibs.push_back(dv);
            if (nibs.size() == 5) begin
               e_valid = 1;
               e_addr  = {nibs[2], nibs[1], nibs[0]};
               e_op    = {nibs[3], nibs[4]};
               m_cnt++;
               nibs.delete();
            end
         end
      end
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check(input string tag, input int ph, input bit lk, input bit er,
                        input bit vl, input logic [11:0] a, input logic [7:0] op,
                        input int unsigned cnt);
      chk({tag, " phase"}, 32'(phase), ph);
      chk({tag, " locked"}, 32'(locked), 32'(lk));
      chk({tag, " sync_err"}, 32'(serr), 32'(er));
      chk({tag, " fetch_valid"}, 32'(fvalid), 32'(vl));
      chk({tag, " fetch_valid w2"}, 32'(fvalid2), 32'(vl));
      if (vl) begin
         chk({tag, " fetch_addr"}, 32'(faddr), 32'(a));
         chk({tag, " fetch_op"}, 32'(fop), 32'(op));
         chk({tag, " fetch_cnt"}, 32'(fcnt), cnt % 65536);
         chk({tag, " fetch_cnt w2"}, 32'(fcnt2), cnt % 4);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " locked"}, 32'(locked | locked2), 0);
      chk({tag, " phase"}, 32'(phase | phase2), 0);
      chk({tag, " fetch_valid"}, 32'(fvalid | fvalid2), 0);
      chk({tag, " fetch_addr"}, 32'(faddr | faddr2), 0);
      chk({tag, " fetch_op"}, 32'(fop | fop2), 0);
      chk({tag, " sync_err"}, 32'(serr | serr2), 0);
      chk({tag, " fetch_cnt"}, 32'(fcnt) | 32'(fcnt2), 0);
   endtask

   // ---------------- stimulus ----------------
   task automatic drive_tick(input bit s, input logic [3:0] dv);
      @(negedge clk);
      phi2 = 1'b1; sync = s; d = dv;
      @(negedge clk);
   endtask

   // Rest of the subcycle: junk on the bus away from the tick, pulse widths checked.
   task automatic finish_sub();
      sync = 1'($urandom_range(0, 1));
      d    = 4'($urandom);
      @(negedge clk);
      chk("fetch_valid width", 32'(fvalid), 0);
      chk("sync_err width", 32'(serr), 0);
      @(negedge clk);
      phi2 = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic model_sub(input string tag, input bit s, input logic [3:0] dv);
      drive_tick(s, dv);
      model_step(s, dv);
      check(tag, m_phase, m_locked, e_err, e_valid, e_addr, e_op, m_cnt);
      finish_sub();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          s;
      logic [3:0]  d;
      int          ph;
      bit          lk;
      bit          er;
      bit          vl;
      logic [11:0] a;
      logic [7:0]  op;
      int unsigned cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit s, logic [3:0] dv, int ph, bit lk, bit er, bit vl,
                               logic [11:0] a, logic [7:0] op, int unsigned cnt);
      vec_t v;
      v = '{s, dv, ph, lk, er, vl, a, op, cnt};
      tbl.push_back(v);
   endfunction

   // One locked cycle A1..X3; x3_sync=0 withholds SYNC at X3.
   function automatic void add_cycle(logic [11:0] a, logic [7:0] op, int unsigned cnt, bit x3_sync);
      add(0, a[3:0],   0, 1, 0, 0, a, op, cnt);
      add(0, a[7:4],   1, 1, 0, 0, a, op, cnt);
      add(0, a[11:8],  2, 1, 0, 0, a, op, cnt);
      add(0, op[7:4],  3, 1, 0, 0, a, op, cnt);
      add(0, op[3:0],  4, 1, 0, 1, a, op, cnt);
      add(0, 4'h0,     5, 1, 0, 0, a, op, cnt);
      add(0, 4'h0,     6, 1, 0, 0, a, op, cnt);
      if (x3_sync) add(1, 4'h0, 7, 1, 0, 0, a, op, cnt);
      else         add(0, 4'h0, 7, 0, 1, 0, a, op, cnt);
   endfunction

   initial begin
      bit          s;
      logic [3:0]  dv;

      add(0, 4'h0, 1, 0, 0, 0, 12'h0, 8'h0, 0);       // free-running, unlocked
      add(1, 4'h0, 7, 1, 0, 0, 12'h0, 8'h0, 0);       // first SYNC locks
      add_cycle(12'h3A5, 8'hD4, 1, 1);                // single fetch
      add_cycle(12'h000, 8'h00, 2, 1);                // back-to-back
      add_cycle(12'h001, 8'h00, 3, 1);
      add_cycle(12'h002, 8'h00, 4, 1);
      add(0, 4'h1, 0, 1, 0, 0, 12'h0, 8'h0, 0);       // early SYNC at M2
      add(0, 4'h2, 1, 1, 0, 0, 12'h0, 8'h0, 0);
      add(0, 4'h3, 2, 1, 0, 0, 12'h0, 8'h0, 0);
      add(0, 4'h4, 3, 1, 0, 0, 12'h0, 8'h0, 0);
      add(1, 4'h5, 7, 1, 1, 0, 12'h0, 8'h0, 0);
      add_cycle(12'h123, 8'h45, 5, 0);                // then SYNC missing at X3
      for (int i = 0; i < 8; i++)                     // unlocked: no capture
         add(0, 4'($urandom), i, 0, 0, 0, 12'h0, 8'h0, 0);
      add(1, 4'h0, 7, 1, 0, 0, 12'h0, 8'h0, 0);
      add_cycle(12'hFED, 8'hCB, 6, 1);

      rst_n = 1'b0; phi2 = 1'b0; sync = 1'b0; d = 4'h0;
      model_reset();
      repeat (4) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive_tick(tbl[i].s, tbl[i].d);
         model_step(tbl[i].s, tbl[i].d);
         check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].lk, tbl[i].er, tbl[i].vl,
               tbl[i].a, tbl[i].op, tbl[i].cnt);
         finish_sub();
      end

      // Randomized traffic: mostly well-formed cycles with occasional bad SYNC.
      for (int i = 0; i < 300; i++) begin
         if (m_phase == 6) s = ($urandom_range(0, 19) != 0);
         else              s = ($urandom_range(0, 29) == 0);
         dv = 4'($urandom);
         model_sub("rand", s, dv);
      end

      // Mid-cycle reset at the A3 tick.
      while (!(m_locked && m_phase == 6)) model_sub("pre-reset", (m_phase == 6), 4'($urandom));
      model_sub("pre-reset sync", 1'b1, 4'h0);
      model_sub("pre-reset A1", 1'b0, 4'h9);
      model_sub("pre-reset A2", 1'b0, 4'h8);
      @(negedge clk);
      phi2 = 1'b1; sync = 1'b0; d = 4'h7; rst_n = 1'b0;
      @(negedge clk);
      check_zero("mid reset");
      @(negedge clk);
      phi2 = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) model_sub("post-reset unlocked", 1'b0, 4'($urandom));
      model_sub("post-reset sync", 1'b1, 4'h0);
      for (int i = 0; i < 7; i++) model_sub("post-reset cycle", 1'b0, 4'($urandom));
      chk("post-reset fetch count", 32'(fcnt), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
